// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: 1 prep cycle, 32 shift-add or
// restoring-divide iterations, and 1 sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_start,
  input  logic        mulu_start,
  input  logic        div_start,
  input  logic        divu_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | waiting for a start pulse; hi/lo hold the last result
  // PREP  | take operand magnitudes, clear accumulator and counter
  // RUN   | 32 iterations, one multiplier/quotient bit per cycle
  // FIX   | sign correction, write hi/lo, pulse done
  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d, sgn_q, sgn_d, done_q, done_d;

  logic        a_neg, b_neg;
  logic [32:0] add_sum, rem_sh, trial;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    a_neg    = sgn_q & a_q[31];
    b_neg    = sgn_q & b_q[31];
    add_sum  = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);
    // Dividend bits are fed in MSB first from opa_q; bit 32 of trial is the borrow.
    rem_sh   = {acc_q[63:32], opa_q[31]};
    trial    = rem_sh - {1'b0, opb_q};
    prod_fix = (a_neg ^ b_neg) ? -acc_q : acc_q;
    quo_fix  = (a_neg ^ b_neg) ? -acc_q[31:0] : acc_q[31:0];
    rem_fix  = a_neg ? -acc_q[63:32] : acc_q[63:32];

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sgn_d    = sgn_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_start | divu_start | mul_start | mulu_start) begin
          a_d     = a;
          b_d     = b;
          state_d = PREP;
          if (div_start) begin
            is_div_d = 1'b1;
            sgn_d    = 1'b1;
          end else if (divu_start) begin
            is_div_d = 1'b1;
            sgn_d    = 1'b0;
          end else if (mul_start) begin
            is_div_d = 1'b0;
            sgn_d    = 1'b1;
          end else begin
            is_div_d = 1'b0;
            sgn_d    = 1'b0;
          end
        end
      end
      PREP: begin
        opa_d   = a_neg ? -a_q : a_q;
        opb_d   = b_neg ? -b_q : b_q;
        acc_d   = 64'd0;
        cnt_d   = 5'd0;
        state_d = RUN;
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = trial[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                            : {trial[31:0],  acc_q[30:0], 1'b1};
          opa_d = opa_q << 1;
        end else begin
          acc_d = {add_sum, acc_q[31:1]};
          opb_d = opb_q >> 1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          if (b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sgn_q    <= sgn_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, 34-cycle latency,
// done pulse width, start filtering while busy, reset abort and start priority.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mul_start = 1'b0, mulu_start = 1'b0, div_start = 1'b0, divu_start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst),
    .mul_start(mul_start), .mulu_start(mulu_start),
    .div_start(div_start), .divu_start(divu_start),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MULT+DIV together. Call at a negedge.
  task automatic start_op(input int kind, input logic [31:0] av, input logic [31:0] bv);
    a = av;
    b = bv;
    mul_start  = (kind == 0 || kind == 4);
    mulu_start = (kind == 1);
    div_start  = (kind == 2 || kind == 4);
    divu_start = (kind == 3);
    @(posedge clk);
    #1;
    mul_start = 0; mulu_start = 0; div_start = 0; divu_start = 0;
    t0 = cyc;
  endtask

  // Returns at the negedge where done is seen (or after a bounded wait).
  task automatic wait_done(input string tag);
    int guard = 0;
    int busy_gaps = 0;
    do begin
      @(negedge clk);
      guard++;
      if (done !== 1'b1 && busy !== 1'b1) busy_gaps++;
    end while (done !== 1'b1 && guard < 60);
    check({tag, " latency"}, 64'(cyc - t0), 64'd34);
    check({tag, " busy held"}, 64'(busy_gaps), 64'd0);
    check({tag, " busy low at done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input int kind, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] hi_e, input logic [31:0] lo_e);
    start_op(kind, av, bv);
    wait_done(tag);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, hi_e});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, lo_e});
    @(negedge clk);
    check({tag, " done width"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int done_seen;
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi",   {32'd0, hi}, 64'd0);
    check("reset lo",   {32'd0, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu max",  1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*7",  0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div -7/2",   2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div min/-1", 2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div -5/0",   2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divu 100/0", 3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    run_op("mult 6*-4",  0, 32'd6,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFE8);
    run_op("divu hex",   3, 32'h1234_5678, 32'h10,        32'h0000_0008, 32'h0123_4567);

    // Operand changes and a second start while busy must not disturb MULTU 3*5.
    start_op(1, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    a = 32'd99;
    b = 32'd77;
    repeat (5) @(negedge clk);
    check("hold hi mid-op", {32'd0, hi}, 64'h8);
    check("hold lo mid-op", {32'd0, lo}, 64'h0123_4567);
    div_start = 1'b1;
    @(posedge clk);
    #1 div_start = 1'b0;
    wait_done("multu 3*5 guarded");
    check("multu 3*5 hi", {32'd0, hi}, 64'd0);
    check("multu 3*5 lo", {32'd0, lo}, 64'd15);
    // Back-to-back start while done is high (edge T35).
    start_op(1, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    check("restart at T35 busy", {63'd0, busy}, 64'd1);
    wait_done("multu 2^16*2^16");
    check("multu 2^32 hi", {32'd0, hi}, 64'd1);
    check("multu 2^32 lo", {32'd0, lo}, 64'd0);
    @(negedge clk);

    // Reset at T15 of a DIV aborts it.
    start_op(2, 32'hFFFF_FFF9, 32'd2);
    while (cyc - t0 < 14) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort hi",   {32'd0, hi}, 64'd0);
    check("abort lo",   {32'd0, lo}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort no done", 64'(done_seen), 64'd0);

    run_op("prio div over mul", 4, 32'd20, 32'd3, 32'd2, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
